// File: rtl/strv32i_pkg.sv
// Shared definitions for the RV32I front end: fetch FSM states,
// pc_unit mux select codes and the boot address.
package strv32i_pkg;

  typedef enum logic [2:0] {
    ST_BOOT = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_HOLD = 3'd3,
    ST_ERR  = 3'd4
  } fetch_state_e;

  // pc_unit select: BOOT forces the boot address, NEXT takes pc+4 or the branch target.
  localparam logic [1:0]  PC_SRC_BOOT = 2'b00;
  localparam logic [1:0]  PC_SRC_NEXT = 2'b11;

  localparam logic [31:0] BOOT_ADDR   = 32'h0000_0000;

endpackage

// File: rtl/ifetch_ctrl_if.sv
// Fetch bus: instruction-memory request channel plus the decode hand-off.
//
// Handshakes:
//   imem: imem_req_out is held with imem_addr_out stable until a cycle with
//         imem_gnt_in=1 accepts it; exactly one imem_rvalid_in pulse later
//         returns imem_rdata_in for that request.
//   decode: a word transfers in a cycle where instr_valid_out && instr_ready_in;
//         while valid is high and ready low, instr_out/instr_pc_out hold stable.
interface ifetch_ctrl_if;
  logic        imem_req_out;
  logic [31:0] imem_addr_out;
  logic        imem_gnt_in;
  logic        imem_rvalid_in;
  logic [31:0] imem_rdata_in;
  logic        instr_valid_out;
  logic [31:0] instr_out;
  logic [31:0] instr_pc_out;
  logic        instr_ready_in;

  // Fetch controller side.
  modport master (
    output imem_req_out, imem_addr_out, instr_valid_out, instr_out, instr_pc_out,
    input  imem_gnt_in, imem_rvalid_in, imem_rdata_in, instr_ready_in
  );

  // Memory / decode side.
  modport slave (
    input  imem_req_out, imem_addr_out, instr_valid_out, instr_out, instr_pc_out,
    output imem_gnt_in, imem_rvalid_in, imem_rdata_in, instr_ready_in
  );
endinterface

// File: rtl/fetch_timeout_cnt.sv
// Clear/enable wait counter with a terminal-count flag at MAX_WAIT.
// Saturates at the terminal value so the flag stays asserted.
module fetch_timeout_cnt #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  output logic [7:0] cnt,
  output logic       tc
);

  localparam logic [7:0] TC_VAL = 8'(MAX_WAIT);

  assign tc = (cnt == TC_VAL);

  // Count enabled cycles since the last clear, holding at the terminal value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= 8'd0;
    end else if (clr) begin
      cnt <= 8'd0;
    end else if (en && !tc) begin
      cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch sequencer: owns the architectural PC, issues one imem
// request at a time, presents fetched words to decode and absorbs execute
// redirects by discarding wrong-path fetches. A memory timeout parks the
// block in a sticky error state until reset.
module ifetch_ctrl
  import strv32i_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic                clk_in,
  input  logic                rst_in,
  output logic [1:0]          pc_src_out,
  output logic [31:0]         pc_out,
  input  logic [31:0]         pc_mux_in,
  input  logic                branch_take_in,
  output logic                fetch_err_out,
  ifetch_ctrl_if.master       bus,
  output fetch_state_e        fetch_state,
  output logic [7:0]          wait_cnt
);

  fetch_state_e state, state_next;

  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic [31:0] instr_pc_q;
  logic        valid_q;
  logic        redirect_pend;
  logic [31:0] redirect_pc;

  // Per-cycle datapath actions decided by the FSM.
  logic load_pc_mux;
  logic load_pc_redir;
  logic capture;
  logic clr_valid;
  logic set_pend;
  logic clr_pend;
  logic cnt_clr;
  logic cnt_en;
  logic cnt_tc;

  fetch_timeout_cnt #(.MAX_WAIT(MAX_WAIT)) u_timeout (
    .clk (clk_in),
    .rst (rst_in),
    .clr (cnt_clr),
    .en  (cnt_en),
    .cnt (wait_cnt),
    .tc  (cnt_tc)
  );

  // State register.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state <= ST_BOOT;
    else        state <= state_next;
  end

  // Next-state and datapath-action decode.
  always_comb begin
    state_next    = state;
    load_pc_mux   = 1'b0;
    load_pc_redir = 1'b0;
    capture       = 1'b0;
    clr_valid     = 1'b0;
    set_pend      = 1'b0;
    clr_pend      = 1'b0;
    cnt_clr       = 1'b0;
    cnt_en        = 1'b0;
    case (state)
      ST_BOOT: begin
        load_pc_mux = 1'b1;
        state_next  = ST_REQ;
      end
      ST_REQ: begin
        // A redirect here cannot cancel the request; remember it instead.
        if (branch_take_in) set_pend = 1'b1;
        if (bus.imem_gnt_in) begin
          cnt_clr    = 1'b1;
          state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_en = 1'b1;
        if (bus.imem_rvalid_in) begin
          if (branch_take_in) begin
            // Newest redirect wins over any pending one.
            load_pc_mux = 1'b1;
            clr_pend    = 1'b1;
            state_next  = ST_REQ;
          end else if (redirect_pend) begin
            load_pc_redir = 1'b1;
            clr_pend      = 1'b1;
            state_next    = ST_REQ;
          end else begin
            capture     = 1'b1;
            load_pc_mux = 1'b1;
            state_next  = ST_HOLD;
          end
        end else begin
          if (branch_take_in) set_pend = 1'b1;
          if (cnt_tc) state_next = ST_ERR;
        end
      end
      ST_HOLD: begin
        if (branch_take_in) begin
          clr_valid   = 1'b1;
          load_pc_mux = 1'b1;
          state_next  = ST_REQ;
        end else if (bus.instr_ready_in) begin
          clr_valid  = 1'b1;
          state_next = ST_REQ;
        end
      end
      ST_ERR: begin
        state_next = ST_ERR;
      end
      default: begin
        state_next = ST_ERR;
      end
    endcase
  end

  // PC, decode output register and pending-redirect bookkeeping.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      pc_q          <= BOOT_ADDR;
      instr_q       <= 32'd0;
      instr_pc_q    <= 32'd0;
      valid_q       <= 1'b0;
      redirect_pend <= 1'b0;
      redirect_pc   <= 32'd0;
    end else begin
      if (load_pc_mux)        pc_q <= pc_mux_in;
      else if (load_pc_redir) pc_q <= redirect_pc;

      if (capture) begin
        instr_q    <= bus.imem_rdata_in;
        instr_pc_q <= pc_q;
        valid_q    <= 1'b1;
      end else if (clr_valid) begin
        valid_q <= 1'b0;
      end

      if (clr_pend) begin
        redirect_pend <= 1'b0;
      end else if (set_pend) begin
        redirect_pend <= 1'b1;
        redirect_pc   <= pc_mux_in;
      end
    end
  end

  // All outputs come from registers or decoded state only.
  assign pc_out              = pc_q;
  assign pc_src_out          = (state == ST_BOOT) ? PC_SRC_BOOT : PC_SRC_NEXT;
  assign fetch_err_out       = (state == ST_ERR);
  assign fetch_state         = state;
  assign bus.imem_req_out    = (state == ST_REQ);
  assign bus.imem_addr_out   = pc_q;
  assign bus.instr_valid_out = valid_q;
  assign bus.instr_out       = instr_q;
  assign bus.instr_pc_out    = instr_pc_q;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed bench for ifetch_ctrl with a behavioural pc_unit and a scoreboard
// of fetched instructions awaiting hand-off to decode.
module tb_ifetch_ctrl;
  import strv32i_pkg::*;

  localparam int unsigned MAX_WAIT = 15;

  logic         clk;
  logic         rst;
  logic [1:0]   pc_src;
  logic [31:0]  pc;
  logic [31:0]  pc_mux;
  logic         branch_take;
  logic [31:0]  br_target;
  logic         fetch_err;
  fetch_state_e fetch_state;
  logic [7:0]   wait_cnt;

  ifetch_ctrl_if bus ();

  ifetch_ctrl #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk_in         (clk),
    .rst_in         (rst),
    .pc_src_out     (pc_src),
    .pc_out         (pc),
    .pc_mux_in      (pc_mux),
    .branch_take_in (branch_take),
    .fetch_err_out  (fetch_err),
    .bus            (bus),
    .fetch_state    (fetch_state),
    .wait_cnt       (wait_cnt)
  );

  // pc_unit stand-in: boot address, branch target, or pc+4.
  always_comb begin
    pc_mux = pc + 32'd4;
    if (pc_src == PC_SRC_BOOT) pc_mux = BOOT_ADDR;
    else if (branch_take)      pc_mux = br_target;
  end

  // Clock and global time limit.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_pc_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"},    32'(fetch_state), 32'(ST_BOOT));
    check({tag, "_pc"},       pc, 32'h0);
    check({tag, "_pc_src"},   32'(pc_src), 32'h0);
    check({tag, "_req"},      32'(bus.imem_req_out), 32'h0);
    check({tag, "_valid"},    32'(bus.instr_valid_out), 32'h0);
    check({tag, "_instr"},    bus.instr_out, 32'h0);
    check({tag, "_instr_pc"}, bus.instr_pc_out, 32'h0);
    check({tag, "_err"},      32'(fetch_err), 32'h0);
    check({tag, "_wait_cnt"}, 32'(wait_cnt), 32'h0);
  endtask

  // Issue from REQ: immediate gnt, rvalid the next cycle; lands in HOLD.
  task automatic fetch(input string tag, input logic [31:0] addr, input logic [31:0] data);
    check({tag, "_req"},  32'(bus.imem_req_out), 32'h1);
    check({tag, "_addr"}, bus.imem_addr_out, addr);
    bus.imem_gnt_in = 1'b1;
    step();
    bus.imem_gnt_in    = 1'b0;
    bus.imem_rvalid_in = 1'b1;
    bus.imem_rdata_in  = data;
    exp_q.push_back(data);
    exp_pc_q.push_back(addr);
    step();
    bus.imem_rvalid_in = 1'b0;
    check({tag, "_valid"}, 32'(bus.instr_valid_out), 32'h1);
    check({tag, "_pc4"},   pc, addr + 32'd4);
  endtask

  // Compare the word on the decode port with the scoreboard head.
  task automatic sb_compare(input string tag, input logic pop);
    check({tag, "_sb_size"}, 32'(exp_q.size()), 32'd1);
    if (exp_q.size() > 0) begin
      check({tag, "_instr"},    bus.instr_out, exp_q[0]);
      check({tag, "_instr_pc"}, bus.instr_pc_out, exp_pc_q[0]);
      if (pop) begin
        void'(exp_q.pop_front());
        void'(exp_pc_q.pop_front());
      end
    end
  endtask

  // Discard a fetched entry that a redirect killed.
  task automatic sb_drop();
    if (exp_q.size() > 0) begin
      void'(exp_q.pop_front());
      void'(exp_pc_q.pop_front());
    end
  endtask

  initial begin
    rst                = 1'b1;
    branch_take        = 1'b0;
    br_target          = 32'h0;
    bus.imem_gnt_in    = 1'b0;
    bus.imem_rvalid_in = 1'b0;
    bus.imem_rdata_in  = 32'h0;
    bus.instr_ready_in = 1'b0;
    step();
    step();
    check_reset_values("por");
    rst = 1'b0;
    check("boot_pc_src", 32'(pc_src), 32'(PC_SRC_BOOT));

    // Boot: one BOOT cycle then first request at address 0.
    step();
    check("boot_to_req", 32'(fetch_state), 32'(ST_REQ));
    check("req_pc_src",  32'(pc_src), 32'(PC_SRC_NEXT));
    fetch("f0", 32'h0, 32'h0000_0013);
    sb_compare("f0_present", 1'b0);

    // Decode back-pressure for 5 cycles.
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_valid", 32'(bus.instr_valid_out), 32'h1);
      check("bp_instr", bus.instr_out, 32'h0000_0013);
      check("bp_req",   32'(bus.imem_req_out), 32'h0);
      check("bp_pc",    pc, 32'h4);
    end
    bus.instr_ready_in = 1'b1;
    sb_compare("f0_accept", 1'b1);
    step();
    bus.instr_ready_in = 1'b0;
    check("f1_valid_drop", 32'(bus.instr_valid_out), 32'h0);
    check("f1_req",        32'(bus.imem_req_out), 32'h1);
    check("f1_addr",       bus.imem_addr_out, 32'h4);

    // Address held stable while gnt is withheld.
    step();
    step();
    check("gnt_stall_req",  32'(bus.imem_req_out), 32'h1);
    check("gnt_stall_addr", bus.imem_addr_out, 32'h4);

    // Redirect in WAIT, data returns 2 cycles later and is discarded.
    bus.imem_gnt_in = 1'b1;
    step();
    bus.imem_gnt_in = 1'b0;
    check("w_state", 32'(fetch_state), 32'(ST_WAIT));
    branch_take = 1'b1;
    br_target   = 32'h100;
    step();
    branch_take = 1'b0;
    step();
    bus.imem_rvalid_in = 1'b1;
    bus.imem_rdata_in  = 32'hDEAD_BEEF;
    step();
    bus.imem_rvalid_in = 1'b0;
    check("wredir_valid", 32'(bus.instr_valid_out), 32'h0);
    check("wredir_state", 32'(fetch_state), 32'(ST_REQ));
    check("wredir_addr",  bus.imem_addr_out, 32'h100);

    // Redirect in HOLD kills the word.
    fetch("f2", 32'h100, 32'h0050_0093);
    branch_take = 1'b1;
    br_target   = 32'h200;
    step();
    branch_take = 1'b0;
    sb_drop();
    check("hredir_valid", 32'(bus.instr_valid_out), 32'h0);
    check("hredir_addr",  bus.imem_addr_out, 32'h200);

    // Two redirects during REQ: the later one wins.
    branch_take = 1'b1;
    br_target   = 32'h300;
    step();
    br_target       = 32'h340;
    bus.imem_gnt_in = 1'b1;
    step();
    branch_take        = 1'b0;
    bus.imem_gnt_in    = 1'b0;
    bus.imem_rvalid_in = 1'b1;
    bus.imem_rdata_in  = 32'h1111_1111;
    step();
    bus.imem_rvalid_in = 1'b0;
    check("dredir_valid", 32'(bus.instr_valid_out), 32'h0);
    check("dredir_addr",  bus.imem_addr_out, 32'h340);

    // Redirect coincident with rvalid.
    bus.imem_gnt_in = 1'b1;
    step();
    bus.imem_gnt_in    = 1'b0;
    bus.imem_rvalid_in = 1'b1;
    bus.imem_rdata_in  = 32'h2222_2222;
    branch_take        = 1'b1;
    br_target          = 32'h400;
    step();
    bus.imem_rvalid_in = 1'b0;
    branch_take        = 1'b0;
    check("credir_valid", 32'(bus.instr_valid_out), 32'h0);
    check("credir_addr",  bus.imem_addr_out, 32'h400);

    // Normal fetch with decode ready.
    bus.instr_ready_in = 1'b1;
    fetch("f3", 32'h400, 32'h0000_0011);
    sb_compare("f3_accept", 1'b1);
    step();
    check("f4_addr", bus.imem_addr_out, 32'h404);
    bus.instr_ready_in = 1'b0;

    // Memory timeout.
    bus.imem_gnt_in = 1'b1;
    step();
    bus.imem_gnt_in = 1'b0;
    for (int i = 0; i < int'(MAX_WAIT); i++) step();
    check("to_state_pre", 32'(fetch_state), 32'(ST_WAIT));
    check("to_cnt_pre",   32'(wait_cnt), 32'(MAX_WAIT));
    check("to_err_pre",   32'(fetch_err), 32'h0);
    step();
    check("to_err",   32'(fetch_err), 32'h1);
    check("to_req",   32'(bus.imem_req_out), 32'h0);
    check("to_valid", 32'(bus.instr_valid_out), 32'h0);
    for (int i = 0; i < 4; i++) begin
      bus.imem_rvalid_in = i[0];
      branch_take        = i[1];
      bus.imem_gnt_in    = 1'b1;
      step();
      check("err_sticky", 32'(fetch_err), 32'h1);
      check("err_noreq",  32'(bus.imem_req_out), 32'h0);
    end
    bus.imem_rvalid_in = 1'b0;
    branch_take        = 1'b0;
    bus.imem_gnt_in    = 1'b0;

    // Reset out of ERR (instr_out held 0x11 before).
    check("pre_rst_instr", bus.instr_out, 32'h0000_0011);
    #2 rst = 1'b1;
    #1;
    check_reset_values("rst_err");
    step();
    rst = 1'b0;
    step();
    check("rs_req_addr", bus.imem_addr_out, 32'h0);
    bus.imem_gnt_in = 1'b1;
    step();
    bus.imem_gnt_in = 1'b0;
    check("rs_wait", 32'(fetch_state), 32'(ST_WAIT));

    // Asynchronous reset mid-WAIT, late rvalid during BOOT ignored.
    #2 rst = 1'b1;
    #1;
    check_reset_values("rst_wait");
    step();
    bus.imem_rvalid_in = 1'b1;
    bus.imem_rdata_in  = 32'h3333_3333;
    rst = 1'b0;
    step();
    bus.imem_rvalid_in = 1'b0;
    check("late_rv_valid", 32'(bus.instr_valid_out), 32'h0);
    check("late_rv_state", 32'(fetch_state), 32'(ST_REQ));
    fetch("f5", 32'h0, 32'h0000_0013);
    bus.instr_ready_in = 1'b1;
    sb_compare("f5_accept", 1'b1);
    step();
    bus.instr_ready_in = 1'b0;
    check("f6_addr", bus.imem_addr_out, 32'h4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ifetch_ctrl.md
# ifetch_ctrl

Instruction-fetch sequencer for the RV32I core; it owns the architectural PC register and drives the `pc_unit` next-PC mux. It issues one instruction-memory request at a time with a req/gnt/rvalid handshake and hands each fetched word to decode with a valid/ready handshake. It also absorbs branch redirects from execute, discarding wrong-path fetches, and flags a sticky error when memory does not respond.

## Interface
- MAX_WAIT, 15: cycles allowed in WAIT before fetch error (range 1..255).
- clk_in  in  1  core clock.
- rst_in  in  1  reset, asynchronous, active-high.
- pc_src_out  out  2  to `pc_unit` pc_src: 2'b00 in BOOT, 2'b11 otherwise.
- pc_out  out  32  architectural PC, feeds `pc_unit` pc_in.
- pc_mux_in  in  32  `pc_unit` pc_mux_out (pc+4 or branch target).
- branch_take_in  in  1  execute redirect; pc_mux_in carries the target this cycle.
- imem_req_out  out  1  memory request.
- imem_addr_out  out  32  request address (= pc_out).
- imem_gnt_in  in  1  request accepted this cycle.
- imem_rvalid_in  in  1  read data valid.
- imem_rdata_in  in  32  read data.
- instr_valid_out  out  1  instruction available to decode.
- instr_out  out  32  fetched instruction.
- instr_pc_out  out  32  address of instr_out.
- instr_ready_in  in  1  decode accepts.
- fetch_err_out  out  1  sticky memory timeout.

## Operation
- States: BOOT, REQ, WAIT, HOLD, ERR.
- Reset values: state=BOOT, pc_out=0, pc_src_out=00, imem_req_out=0, instr_valid_out=0, instr_out=0, instr_pc_out=0, fetch_err_out=0, redirect_pend=0, wait_cnt=0.
- BOOT: pc_src_out=00. Next cycle: pc_out <= pc_mux_in (0x0000_0000), then go to REQ.
- REQ: imem_req_out=1. imem_addr_out holds stable until gnt. On gnt: wait_cnt <= 0, go to WAIT.
- WAIT: wait_cnt increments each cycle.
  - On rvalid with no redirect pending: instr_out <= rdata, instr_pc_out <= pc_out, instr_valid_out <= 1, pc_out <= pc_mux_in (pc+4), go to HOLD.
  - If wait_cnt reaches MAX_WAIT with no rvalid: go to ERR.
- HOLD: when instr_valid_out && instr_ready_in, drop valid and go to REQ.
- Redirect (branch_take_in=1) by state:
  - HOLD: kill instr_valid_out, pc_out <= pc_mux_in, go to REQ.
  - REQ or WAIT: redirect_pc <= pc_mux_in, redirect_pend <= 1. The in-flight transaction completes normally.
  - On rvalid with redirect_pend=1: data discarded, instr_valid_out stays 0, pc_out <= redirect_pc, redirect_pend <= 0, go to REQ.
  - Ignored in BOOT and ERR.
- branch_take_in and rvalid in the same WAIT cycle: data discarded, pc_out <= pc_mux_in, go to REQ.
- A second redirect while one is pending overwrites redirect_pc.
- ERR: imem_req_out=0, instr_valid_out=0, fetch_err_out=1. Leaves ERR only on reset.

## Timing
- pc_src_out, imem_req_out and imem_addr_out are decoded from registered state and registers only; no input-to-output combinational paths.
- Best-case fetch: gnt in the first REQ cycle and rvalid one cycle later. instr_valid_out rises 2 cycles after REQ entry.
- Best-case throughput: 1 instruction per 3 cycles (REQ, WAIT, HOLD).
- Decode back-pressure holds instr_out and instr_pc_out stable.
- Reset asserted mid-transaction forces all outputs to their reset values immediately. A late rvalid after reset release is ignored in BOOT.

## Structure
- Shared package `strv32i_pkg` holds:
  - the fetch state enum;
  - PC_SRC_BOOT = 2'b00 and PC_SRC_NEXT = 2'b11, also used by `pc_unit` users;
  - BOOT_ADDR = 32'h0.
- One sub-module, `fetch_timeout_cnt`: clear/enable counter with a terminal-count flag at MAX_WAIT. Everything else stays in ifetch_ctrl.

## Test plan
- Reset release, gnt immediate, rvalid next cycle, rdata=0x00000013, ready=1 -> first instr_pc_out=0x0, then second imem_addr_out=0x4.
- Decode ready held low 5 cycles in HOLD -> instr_out stable, no new imem_req_out, pc_out=0x4 throughout.
- branch_take_in in WAIT with pc_mux_in=0x100, rvalid 2 cycles later -> no instr_valid_out, next imem_addr_out=0x100.
- branch_take_in in HOLD with pc_mux_in=0x200 -> instr_valid_out drops the next cycle, next request at 0x200.
- rvalid withheld for MAX_WAIT cycles -> fetch_err_out=1, imem_req_out=0 until reset.
- rst_in asserted during WAIT -> all outputs at reset values asynchronously, restart fetch at 0x0.
